ti_adc_capture_ctrl: RTL

//  Snapshot capture sequencer for the time-interleaved SAR ADC.
//  - Sits in the adc_coreclk domain, behind the ti_adc_hfck word array.
//  - Arms on start, waits for a trigger, then stores N (optionally decimated) full-way frames in a buffer.
//  - Drains the buffer one sub-ADC sample per beat over a valid/ready stream to the digital back end.

---
 rtl/ti_adc_pkg.sv | 35 +++
 rtl/capture_mem.sv | 39 +++
 rtl/ti_adc_capture_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ti_adc_pkg.sv
// -----------------------------------------------------------------------------
// ti_adc_pkg
// Shared types and constants for the time-interleaved ADC capture path.
//   cap_state_t    : capture sequencer states
//   DEF_*          : default geometry of the ADC front end
//   FRAME_W        : width of one packed frame (way 0 in the MSBs)
//   clamp_nframes  : maps a requested frame count onto 1..depth
// -----------------------------------------------------------------------------
package ti_adc_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DRAIN   = 2'd3
    } cap_state_t;

    localparam int DEF_ADC_WAYS = 8;
    localparam int DEF_ADC_BITS = 9;
    localparam int DEF_DEPTH    = 64;

    // One frame holds every way side by side; way 0 occupies the MSBs so a
    // packed [0:WAYS-1][0:BITS-1] word array maps onto it without reordering.
    localparam int FRAME_W = DEF_ADC_WAYS * DEF_ADC_BITS;

    // A request of 0 means "fill the whole buffer"; anything larger than the
    // buffer is clamped to the buffer size.
    function automatic int clamp_nframes(input int req, input int depth);
        if (req == 0 || req > depth) begin
            return depth;
        end
        return req;
    endfunction

endpackage

// File: rtl/capture_mem.sv
// -----------------------------------------------------------------------------
// capture_mem
// Simple dual-port frame buffer: one write port, one synchronous read port
// with a single cycle of read latency. Contents are not reset.
//   clk      in   core clock
//   wr_en    in   write strobe
//   wr_addr  in   write frame address
//   wr_data  in   frame to store
//   rd_en    in   read strobe; rd_data updates on the following edge
//   rd_addr  in   read frame address
//   rd_data  out  registered read frame
// -----------------------------------------------------------------------------
module capture_mem
    import ti_adc_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = FRAME_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/ti_adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// ti_adc_capture_ctrl
// Snapshot capture sequencer for the time-interleaved SAR ADC. Arms on start,
// waits for a trigger, stores nframes (optionally decimated) frames and then
// drains them one sub-ADC word per beat over a valid/ready stream.
//   clk        in   core clock
//   rst_n      in   asynchronous active-low reset
//   adc_data   in   one frame per clock, way 0 first, bit 0 = MSB
//   start      in   latch decim/nframes and arm (IDLE only)
//   abort      in   return to IDLE from any state, highest priority
//   trig       in   capture trigger, honoured in ARMED only
//   decim      in   keep one frame in every decim+1
//   nframes    in   frames to capture; 0 or >DEPTH means DEPTH
//   out_data   out  sample word, same bit order as adc_data
//   out_way    out  way index of out_data
//   out_frame  out  frame index of out_data
//   out_last   out  final beat of the capture
//   out_valid  out  stream valid
//   out_ready  in   stream ready
//   busy       out  sequencer not idle
//   done       out  one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module ti_adc_capture_ctrl
    import ti_adc_pkg::*;
#(
    parameter int ADC_WAYS = DEF_ADC_WAYS,
    parameter int ADC_BITS = DEF_ADC_BITS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [0:ADC_WAYS-1][0:ADC_BITS-1]    adc_data,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 trig,
    input  logic [7:0]                           decim,
    input  logic [$clog2(DEPTH):0]               nframes,
    output logic [0:ADC_BITS-1]                  out_data,
    output logic [$clog2(ADC_WAYS)-1:0]          out_way,
    output logic [$clog2(DEPTH)-1:0]             out_frame,
    output logic                                 out_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(ADC_WAYS);
    localparam int FW = ADC_WAYS * ADC_BITS;
    localparam logic [WW-1:0] LAST_WAY = WW'(ADC_WAYS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cap_state_t      state_q,  state_d;
    logic [FW-1:0]   in_q;                    // input frame register
    logic            wr_en_q,  wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [CW-1:0]   cnt_q,    cnt_d;         // frames selected so far
    logic [CW-1:0]   nfr_q,    nfr_d;         // effective frame count
    logic [7:0]      decim_q,  decim_d;
    logic [7:0]      dec_q,    dec_d;         // frames left to skip
    logic            req_q,    req_d;         // issue a buffer read this cycle
    logic            fetch_q,  fetch_d;       // read data is available
    logic            valid_q,  valid_d;
    logic [WW-1:0]   way_q,    way_d;
    logic [AW-1:0]   frame_q,  frame_d;
    logic [FW-1:0]   fr_q,     fr_d;          // frame being serialised
    logic            done_q,   done_d;

    logic [FW-1:0]   rd_data;
    logic            last_frame;
    logic            beat_xfer;

    // ------------------------------------------------------------------
    // Frame buffer. The write is pipelined one cycle behind the select
    // decision so that it always stores the input-register copy of the
    // frame that was registered on the deciding edge.
    // ------------------------------------------------------------------
    capture_mem #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_q),
        .wr_addr (wr_addr_q),
        .wr_data (in_q),
        .rd_en   (req_q),
        .rd_addr (frame_q),
        .rd_data (rd_data)
    );

    assign last_frame = (CW'(frame_q) == (nfr_q - CW'(1)));
    assign beat_xfer  = valid_q & out_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        nfr_d     = nfr_q;
        decim_d   = decim_q;
        dec_d     = dec_q;
        req_d     = 1'b0;
        fetch_d   = 1'b0;
        valid_d   = valid_q;
        way_d     = way_q;
        frame_d   = frame_q;
        fr_d      = fr_q;
        done_d    = 1'b0;

        unique case (state_q)
            CAP_IDLE: begin
                if (start) begin
                    state_d = CAP_ARMED;
                    decim_d = decim;
                    nfr_d   = CW'(clamp_nframes(int'(nframes), DEPTH));
                    cnt_d   = '0;
                end
            end

            CAP_ARMED: begin
                // The trigger frame is always kept and restarts the
                // decimation phase.
                if (trig) begin
                    state_d   = CAP_CAPTURE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    cnt_d     = CW'(1);
                    dec_d     = decim_q;
                end
            end

            CAP_CAPTURE: begin
                // Leaving only once the count is reached lets the final
                // pipelined write land before the first buffer read.
                if (cnt_q == nfr_q) begin
                    state_d = CAP_DRAIN;
                    req_d   = 1'b1;
                    frame_d = '0;
                    way_d   = '0;
                end else if (dec_q == 8'd0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[AW-1:0];
                    cnt_d     = cnt_q + CW'(1);
                    dec_d     = decim_q;
                end else begin
                    dec_d = dec_q - 8'd1;
                end
            end

            CAP_DRAIN: begin
                // req -> fetch -> valid gives the two idle cycles at DRAIN
                // entry and between frames.
                fetch_d = req_q;
                if (fetch_q) begin
                    fr_d    = rd_data;
                    valid_d = 1'b1;
                    way_d   = '0;
                end
                if (beat_xfer) begin
                    if (way_q == LAST_WAY) begin
                        valid_d = 1'b0;
                        if (last_frame) begin
                            done_d  = 1'b1;
                            state_d = CAP_IDLE;
                        end else begin
                            frame_d = frame_q + AW'(1);
                            req_d   = 1'b1;
                        end
                    end else begin
                        way_d = way_q + WW'(1);
                    end
                end
            end

            default: state_d = CAP_IDLE;
        endcase

        // Abort overrides everything decided above.
        if (abort) begin
            state_d = CAP_IDLE;
            wr_en_d = 1'b0;
            req_d   = 1'b0;
            fetch_d = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CAP_IDLE;
            in_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            nfr_q     <= '0;
            decim_q   <= '0;
            dec_q     <= '0;
            req_q     <= 1'b0;
            fetch_q   <= 1'b0;
            valid_q   <= 1'b0;
            way_q     <= '0;
            frame_q   <= '0;
            fr_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_q      <= adc_data;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            nfr_q     <= nfr_d;
            decim_q   <= decim_d;
            dec_q     <= dec_d;
            req_q     <= req_d;
            fetch_q   <= fetch_d;
            valid_q   <= valid_d;
            way_q     <= way_d;
            frame_q   <= frame_d;
            fr_q      <= fr_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Output serializer: split the frame register into its way words.
    // ------------------------------------------------------------------
    logic [0:ADC_BITS-1] way_word [ADC_WAYS];

    for (genvar gi = 0; gi < ADC_WAYS; gi++) begin : g_unpack
        assign way_word[gi] = fr_q[FW-1-gi*ADC_BITS -: ADC_BITS];
    end

    assign out_data  = way_word[way_q];
    assign out_way   = way_q;
    assign out_frame = frame_q;
    assign out_valid = valid_q;
    assign out_last  = valid_q & (way_q == LAST_WAY) & last_frame;
    assign busy      = (state_q != CAP_IDLE);
    assign done      = done_q;

endmodule
